tec_seq_ctrl: RTL and testbench
===============================

Name: tec_seq_ctrl

Overview:
- Parametrised successor to the hardwired TEC controller.
- Generates its own beat timing (W1..W3) and console/run state internally, instead of taking them from the board.
- Adds operator step handshaking, a configurable register file address width and explicit halt/pause states.
- Sits between the console switches/IR latch and the datapath control lines.

Parameters:
REG_AW, 2, register address bits; register file has 2**REG_AW entries; SEL width = 2*REG_AW.
IR_W, 4, opcode width; only IR[IR_W-1 -: 4] is decoded, lower bits are ignored.

Ports:
T3  in  1  clock, rising edge
CLR  in  1  reset, synchronous, active-high
START  in  1  operator step/start pulse, one cycle
SW  in  3  console mode {SWC,SWB,SWA}
IR  in  IR_W  instruction register
C  in  1  carry flag
Z  in  1  zero flag
W  out  3  one-hot beat; 000 when not executing
CTRL  out  16  {SELCTL,DRW,LPC,PCINC,PCADD,LAR,ARINC,LIR,LDZ,LDC,CIN,M,MEMW,ABUS,SBUS,MBUS}, MSB first
S  out  4  ALU function
SEL  out  2*REG_AW  {dest/left index, source/right index}
STOP  out  1  clock-stop request to board; high in IDLE, PAUSE, HALT
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - state=IDLE, W=000, CTRL=0, S=0000, SEL=0, STOP=1, BUSY=0.
  - Internal first-step flag (FS) and register index counter (RIX) cleared.
  - CLR has priority over every other input, including during execution.
- States: IDLE, CON (console step), PAUSE, FETCH, EXEC, HALT.
- Mode latch:
  - In IDLE, START latches SW into mode register MD, sets FS=1, RIX=0, and moves to CON (MD≠000) or FETCH-prep (MD=000, see Run).
  - SW changes while BUSY are ignored.
  - SW=101/110/111: START ignored, stay IDLE.
- Console step:
  - CON lasts exactly one cycle with W=001, SELCTL=1, then PAUSE.
  - From PAUSE, START returns to CON.
- MD=100 write reg: CON asserts SBUS, DRW, SEL={RIX,RIX}; RIX increments modulo 2**REG_AW.
- MD=011 read reg: SEL={RIX,RIX+1}; RIX increments by 2 modulo 2**REG_AW; no writes.
- MD=001 write mem:
  - FS=1: SBUS, LAR; then FS cleared.
  - FS=0: SBUS, MEMW, ARINC.
- MD=010 read mem:
  - FS=1: SBUS, LAR; then FS cleared.
  - FS=0: MBUS, ARINC.
- Run (MD=000):
  - First cycle: W=001, SELCTL=1, SBUS, LPC (PC from switches), then FETCH.
  - FETCH: one beat W=001, LIR, PCINC, then EXEC.
  - EXEC: W starts 001 and shifts left each cycle; after the opcode's last beat, go to FETCH. SELCTL=0, SEL={IR[3:2],IR[1:0]} zero-extended to REG_AW.
- Opcode table (op: beats; signals; S):
  - 0 NOP: 1 beat; none.
  - 1 ADD: 1 beat; ABUS, DRW, LDZ, LDC, CIN; S=1001.
  - 2 SUB: 1 beat; ABUS, DRW, LDZ, LDC; S=0110.
  - 3 AND: 1 beat; ABUS, DRW, LDZ, M; S=1011.
  - 4 INC: 1 beat; ABUS, DRW, LDZ, LDC; S=0000.
  - B OR: 1 beat; ABUS, DRW, LDZ, M; S=1110.
  - C CMP: 1 beat; LDZ, LDC; S=0110.
  - D MOV: 1 beat; ABUS, DRW, M; S=1010.
  - A OUT: 1 beat; ABUS, M; S=1010.
  - 5 LD: 2 beats. W1: ABUS, M, LAR, S=1010. W2: MBUS, DRW.
  - 6 ST: 2 beats. W1: ABUS, M, LAR, S=1111. W2: ABUS, M, MEMW, S=1010.
  - 7 JC / 8 JZ: 1 beat; PCADD only if C / Z is 1.
  - 9 JMP: 1 beat; ABUS, M, LPC; S=1111.
  - E STP: 1 beat; no control lines; then HALT.
  - F (undefined): treated as NOP.
- HALT:
  - STOP=1, W=000, CTRL=0.
  - Left only by CLR; START ignored.
- Outputs are decoded combinationally from registered state/W/MD/FS/RIX and the IR/C/Z inputs; no output depends on START combinationally.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined: in run mode, after the last EXEC beat the block goes to PAUSE (STOP=1) instead of FETCH. START then resumes at FETCH.
- Undefined: run mode executes continuously until STP or CLR; PAUSE is reachable only from console modes.

Test Plan:
- CLR held 2 cycles mid-EXEC of LD (W=010) -> next cycle state IDLE, W=000, CTRL=0, STOP=1, BUSY=0.
- SW=100, START ×5, REG_AW=2 -> SEL=0000, 0101, 1010, 1111, 0000 on the CON cycles. Each CON cycle has SBUS=DRW=SELCTL=1; W=001 for one cycle, then PAUSE.
- SW=001, START ×3 -> first CON cycle LAR=SBUS=1. Next two CON cycles SBUS=MEMW=ARINC=1, LAR=0.
- SW=000, IR=0x5 (LD) after fetch -> W 001 (LAR, ABUS, M, S=1010), then 010 (MBUS, DRW), then FETCH with LIR=PCINC=1.
- IR=0x7 with C=1 then C=0 -> PCADD=1 in the first EXEC, 0 in the second. Both instructions take exactly one EXEC beat.
- IR=0xE -> HALT with STOP=1. Further START pulses cause no change; CLR returns to IDLE. With SINGLE_STEP_EN, IR=0x1 ends in PAUSE, and START resumes at FETCH.

Source files
------------

// File: rtl/tec_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tec_seq_ctrl
//   TEC datapath sequencer. Generates its own beat timing (W1..W3) and
//   console/run state, decodes console modes and the opcode nibble of IR into
//   the datapath control lines, and handshakes operator steps via START.
//
//   Optional build macro: SINGLE_STEP_EN
//     defined   - run mode stops in PAUSE after each instruction; START
//                 resumes at FETCH.
//     undefined - run mode executes continuously until STP or CLR.
//
// Parameters
//   REG_AW  register address bits (register file has 2**REG_AW entries)
//   IR_W    instruction width (>= 4); opcode is IR[IR_W-1 -: 4]
//
// Ports
//   T3     clock, rising edge
//   CLR    synchronous active-high reset, highest priority
//   START  one-cycle operator step/start pulse
//   SW     console mode {SWC,SWB,SWA}, latched only in IDLE
//   IR     instruction register
//   C, Z   carry / zero flags
//   W      one-hot beat, 000 when not executing
//   CTRL   {SELCTL,DRW,LPC,PCINC,PCADD,LAR,ARINC,LIR,LDZ,LDC,CIN,M,MEMW,
//           ABUS,SBUS,MBUS}
//   S      ALU function
//   SEL    {dest/left index, source/right index}
//   STOP   clock-stop request (IDLE, PAUSE, HALT)
//   BUSY   high in every state except IDLE
// -----------------------------------------------------------------------------
module tec_seq_ctrl #(
  parameter int unsigned REG_AW = 2,
  parameter int unsigned IR_W   = 4
) (
  input  logic                  T3,
  input  logic                  CLR,
  input  logic                  START,
  input  logic [2:0]            SW,
  input  logic [IR_W-1:0]       IR,
  input  logic                  C,
  input  logic                  Z,
  output logic [2:0]            W,
  output logic [15:0]           CTRL,
  output logic [3:0]            S,
  output logic [2*REG_AW-1:0]   SEL,
  output logic                  STOP,
  output logic                  BUSY
);

  // CTRL bit positions
  localparam int unsigned CB_SELCTL = 15;
  localparam int unsigned CB_DRW    = 14;
  localparam int unsigned CB_LPC    = 13;
  localparam int unsigned CB_PCINC  = 12;
  localparam int unsigned CB_PCADD  = 11;
  localparam int unsigned CB_LAR    = 10;
  localparam int unsigned CB_ARINC  = 9;
  localparam int unsigned CB_LIR    = 8;
  localparam int unsigned CB_LDZ    = 7;
  localparam int unsigned CB_LDC    = 6;
  localparam int unsigned CB_CIN    = 5;
  localparam int unsigned CB_M      = 4;
  localparam int unsigned CB_MEMW   = 3;
  localparam int unsigned CB_ABUS   = 2;
  localparam int unsigned CB_SBUS   = 1;
  localparam int unsigned CB_MBUS   = 0;

  // Console modes
  localparam logic [2:0] MD_RUN  = 3'b000;
  localparam logic [2:0] MD_WMEM = 3'b001;
  localparam logic [2:0] MD_RMEM = 3'b010;
  localparam logic [2:0] MD_RREG = 3'b011;
  localparam logic [2:0] MD_WREG = 3'b100;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_OR  = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_STP = 4'hE;

  // ST_PREP is the one-cycle PC load that opens run mode
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CON,
    ST_PAUSE,
    ST_PREP,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        md_q, md_d;
  logic              fs_q, fs_d;
  logic [REG_AW-1:0] rix_q, rix_d;
  logic [2:0]        beat_q, beat_d;

  logic [3:0]        op;
  logic              two_beat;
  logic              last_beat;
  logic [REG_AW-1:0] rix_p1;

  assign op        = IR[IR_W-1 -: 4];
  assign two_beat  = (op == OP_LD) || (op == OP_ST);
  assign last_beat = two_beat ? beat_q[1] : beat_q[0];
  assign rix_p1    = rix_q + REG_AW'(1);

  // State register; CLR overrides everything
  always_ff @(posedge T3) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      md_q    <= MD_RUN;
      fs_q    <= 1'b0;
      rix_q   <= '0;
      beat_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      md_q    <= md_d;
      fs_q    <= fs_d;
      rix_q   <= rix_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    md_d    = md_q;
    fs_d    = fs_q;
    rix_d   = rix_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        // modes 101..111 are not defined; START is ignored for them
        if (START && (SW <= MD_WREG)) begin
          md_d    = SW;
          fs_d    = 1'b1;
          rix_d   = '0;
          state_d = (SW == MD_RUN) ? ST_PREP : ST_CON;
        end
      end
      ST_CON: begin
        state_d = ST_PAUSE;
        fs_d    = 1'b0;
        case (md_q)
          MD_WREG: rix_d = rix_q + REG_AW'(1);
          MD_RREG: rix_d = rix_q + REG_AW'(2);
          default: rix_d = rix_q;
        endcase
      end
      ST_PAUSE: begin
        // a run-mode PAUSE only exists in single-step builds
        if (START) begin
          state_d = (md_q == MD_RUN) ? ST_FETCH : ST_CON;
        end
      end
      ST_PREP: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
        beat_d  = 3'b001;
      end
      ST_EXEC: begin
        if (last_beat) begin
          beat_d = 3'b000;
          if (op == OP_STP) begin
            state_d = ST_HALT;
          end else begin
`ifdef SINGLE_STEP_EN
            state_d = ST_PAUSE;
`else
            state_d = ST_FETCH;
`endif
          end
        end else begin
          beat_d = {beat_q[1:0], 1'b0};
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state plus IR/C/Z
  always_comb begin
    W    = 3'b000;
    CTRL = 16'h0000;
    S    = 4'b0000;
    SEL  = '0;
    STOP = 1'b0;
    BUSY = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE, ST_PAUSE, ST_HALT: begin
        STOP = 1'b1;
      end
      ST_CON: begin
        W              = 3'b001;
        CTRL[CB_SELCTL] = 1'b1;
        case (md_q)
          MD_WREG: begin
            CTRL[CB_SBUS] = 1'b1;
            CTRL[CB_DRW]  = 1'b1;
            SEL           = {rix_q, rix_q};
          end
          MD_RREG: begin
            SEL = {rix_q, rix_p1};
          end
          MD_WMEM: begin
            CTRL[CB_SBUS] = 1'b1;
            if (fs_q) begin
              CTRL[CB_LAR] = 1'b1;
            end else begin
              CTRL[CB_MEMW]  = 1'b1;
              CTRL[CB_ARINC] = 1'b1;
            end
          end
          MD_RMEM: begin
            if (fs_q) begin
              CTRL[CB_SBUS] = 1'b1;
              CTRL[CB_LAR]  = 1'b1;
            end else begin
              CTRL[CB_MBUS]  = 1'b1;
              CTRL[CB_ARINC] = 1'b1;
            end
          end
          default: begin
            CTRL[CB_SELCTL] = 1'b1;
          end
        endcase
      end
      ST_PREP: begin
        // PC loaded from the console switches
        W               = 3'b001;
        CTRL[CB_SELCTL] = 1'b1;
        CTRL[CB_SBUS]   = 1'b1;
        CTRL[CB_LPC]    = 1'b1;
      end
      ST_FETCH: begin
        W              = 3'b001;
        CTRL[CB_LIR]   = 1'b1;
        CTRL[CB_PCINC] = 1'b1;
      end
      ST_EXEC: begin
        W   = beat_q;
        SEL = {REG_AW'(IR[3:2]), REG_AW'(IR[1:0])};
        case (op)
          OP_ADD: begin
            CTRL[CB_ABUS] = 1'b1;
            CTRL[CB_DRW]  = 1'b1;
            CTRL[CB_LDZ]  = 1'b1;
            CTRL[CB_LDC]  = 1'b1;
            CTRL[CB_CIN]  = 1'b1;
            S             = 4'b1001;
          end
          OP_SUB: begin
            CTRL[CB_ABUS] = 1'b1;
            CTRL[CB_DRW]  = 1'b1;
            CTRL[CB_LDZ]  = 1'b1;
            CTRL[CB_LDC]  = 1'b1;
            S             = 4'b0110;
          end
          OP_AND: begin
            CTRL[CB_ABUS] = 1'b1;
            CTRL[CB_DRW]  = 1'b1;
            CTRL[CB_LDZ]  = 1'b1;
            CTRL[CB_M]    = 1'b1;
            S             = 4'b1011;
          end
          OP_INC: begin
            CTRL[CB_ABUS] = 1'b1;
            CTRL[CB_DRW]  = 1'b1;
            CTRL[CB_LDZ]  = 1'b1;
            CTRL[CB_LDC]  = 1'b1;
            S             = 4'b0000;
          end
          OP_OR: begin
            CTRL[CB_ABUS] = 1'b1;
            CTRL[CB_DRW]  = 1'b1;
            CTRL[CB_LDZ]  = 1'b1;
            CTRL[CB_M]    = 1'b1;
            S             = 4'b1110;
          end
          OP_CMP: begin
            CTRL[CB_LDZ] = 1'b1;
            CTRL[CB_LDC] = 1'b1;
            S            = 4'b0110;
          end
          OP_MOV: begin
            CTRL[CB_ABUS] = 1'b1;
            CTRL[CB_DRW]  = 1'b1;
            CTRL[CB_M]    = 1'b1;
            S             = 4'b1010;
          end
          OP_OUT: begin
            CTRL[CB_ABUS] = 1'b1;
            CTRL[CB_M]    = 1'b1;
            S             = 4'b1010;
          end
          OP_LD: begin
            if (beat_q[0]) begin
              CTRL[CB_ABUS] = 1'b1;
              CTRL[CB_M]    = 1'b1;
              CTRL[CB_LAR]  = 1'b1;
              S             = 4'b1010;
            end else begin
              CTRL[CB_MBUS] = 1'b1;
              CTRL[CB_DRW]  = 1'b1;
            end
          end
          OP_ST: begin
            CTRL[CB_ABUS] = 1'b1;
            CTRL[CB_M]    = 1'b1;
            if (beat_q[0]) begin
              CTRL[CB_LAR] = 1'b1;
              S            = 4'b1111;
            end else begin
              CTRL[CB_MEMW] = 1'b1;
              S             = 4'b1010;
            end
          end
          OP_JC: begin
            CTRL[CB_PCADD] = C;
          end
          OP_JZ: begin
            CTRL[CB_PCADD] = Z;
          end
          OP_JMP: begin
            CTRL[CB_ABUS] = 1'b1;
            CTRL[CB_M]    = 1'b1;
            CTRL[CB_LPC]  = 1'b1;
            S             = 4'b1111;
          end
          // NOP, STP and the undefined opcode drive no control lines
          default: begin
            S = 4'b0000;
          end
        endcase
      end
      default: begin
        STOP = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_tec_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tec_seq_ctrl
//   Self-checking bench for tec_seq_ctrl (REG_AW=2, IR_W=4): a hand-written
//   opcode vector table, randomized console sessions and instruction streams
//   scored against a behavioural model, and directed reset/halt sequences.
// -----------------------------------------------------------------------------
module tb_tec_seq_ctrl;

  localparam int unsigned REG_AW = 2;
  localparam int unsigned IR_W   = 4;

  localparam logic [15:0] K_SELCTL = 16'h8000;
  localparam logic [15:0] K_DRW    = 16'h4000;
  localparam logic [15:0] K_LPC    = 16'h2000;
  localparam logic [15:0] K_PCINC  = 16'h1000;
  localparam logic [15:0] K_PCADD  = 16'h0800;
  localparam logic [15:0] K_LAR    = 16'h0400;
  localparam logic [15:0] K_ARINC  = 16'h0200;
  localparam logic [15:0] K_LIR    = 16'h0100;
  localparam logic [15:0] K_LDZ    = 16'h0080;
  localparam logic [15:0] K_LDC    = 16'h0040;
  localparam logic [15:0] K_CIN    = 16'h0020;
  localparam logic [15:0] K_M      = 16'h0010;
  localparam logic [15:0] K_MEMW   = 16'h0008;
  localparam logic [15:0] K_ABUS   = 16'h0004;
  localparam logic [15:0] K_SBUS   = 16'h0002;
  localparam logic [15:0] K_MBUS   = 16'h0001;

  logic                 T3 = 1'b0;
  logic                 CLR;
  logic                 START;
  logic [2:0]           SW;
  logic [IR_W-1:0]      IR;
  logic                 C;
  logic                 Z;
  logic [2:0]           W;
  logic [15:0]          CTRL;
  logic [3:0]           S;
  logic [2*REG_AW-1:0]  SEL;
  logic                 STOP;
  logic                 BUSY;

  int n_chk  = 0;
  int n_pass = 0;

  tec_seq_ctrl #(.REG_AW(REG_AW), .IR_W(IR_W)) dut (
    .T3   (T3),
    .CLR  (CLR),
    .START(START),
    .SW   (SW),
    .IR   (IR),
    .C    (C),
    .Z    (Z),
    .W    (W),
    .CTRL (CTRL),
    .S    (S),
    .SEL  (SEL),
    .STOP (STOP),
    .BUSY (BUSY)
  );

  always #5 T3 = ~T3;

  typedef struct {
    logic [2:0]  w;
    logic [15:0] ctrl;
    logic [3:0]  s;
    logic [3:0]  sel;
    logic        stop;
    logic        busy;
  } obs_t;

  typedef struct {
    logic [3:0]  ir;
    logic        c;
    logic        z;
    int          beats;
    logic [15:0] c1;
    logic [3:0]  s1;
    logic [15:0] c2;
    logic [3:0]  s2;
  } vec_t;

  obs_t o_idle, o_pause, o_halt, o_prep, o_fetch;
  vec_t tbl [17];

  function automatic obs_t mk(input logic [2:0] w, input logic [15:0] ctrl,
                              input logic [3:0] s, input logic [3:0] sel,
                              input logic stop, input logic busy);
    obs_t o;
    o.w = w; o.ctrl = ctrl; o.s = s; o.sel = sel; o.stop = stop; o.busy = busy;
    return o;
  endfunction

  // Console step outputs from mode, first-step flag and register index
  function automatic obs_t con_model(input logic [2:0] md, input bit fs, input int rix);
    obs_t o;
    o = mk(3'b001, K_SELCTL, 4'b0000, 4'b0000, 1'b0, 1'b1);
    case (md)
      3'b100: begin
        o.ctrl = o.ctrl | K_SBUS | K_DRW;
        o.sel  = 4'((rix % 4) * 4 + (rix % 4));
      end
      3'b011: o.sel = 4'((rix % 4) * 4 + ((rix + 1) % 4));
      3'b001: o.ctrl = o.ctrl | (fs ? (K_SBUS | K_LAR) : (K_SBUS | K_MEMW | K_ARINC));
      3'b010: o.ctrl = o.ctrl | (fs ? (K_SBUS | K_LAR) : (K_MBUS | K_ARINC));
      default: o.ctrl = o.ctrl;
    endcase
    return o;
  endfunction

  function automatic int op_beats(input logic [3:0] op);
    return (op == 4'h5 || op == 4'h6) ? 2 : 1;
  endfunction

  // Expected outputs on beat n (1 or 2) of an instruction
  function automatic obs_t exec_model(input logic [3:0] op, input logic c,
                                      input logic z, input int n);
    logic [15:0] k;
    logic [3:0]  s;
    k = 16'h0000;
    s = 4'b0000;
    case (op)
      4'h1: begin k = K_ABUS | K_DRW | K_LDZ | K_LDC | K_CIN; s = 4'b1001; end
      4'h2: begin k = K_ABUS | K_DRW | K_LDZ | K_LDC;         s = 4'b0110; end
      4'h3: begin k = K_ABUS | K_DRW | K_LDZ | K_M;           s = 4'b1011; end
      4'h4: begin k = K_ABUS | K_DRW | K_LDZ | K_LDC;         s = 4'b0000; end
      4'h5: if (n == 1) begin k = K_ABUS | K_M | K_LAR; s = 4'b1010; end
            else k = K_MBUS | K_DRW;
      4'h6: if (n == 1) begin k = K_ABUS | K_M | K_LAR;  s = 4'b1111; end
            else begin        k = K_ABUS | K_M | K_MEMW; s = 4'b1010; end
      4'h7: k = c ? K_PCADD : 16'h0000;
      4'h8: k = z ? K_PCADD : 16'h0000;
      4'h9: begin k = K_ABUS | K_M | K_LPC;          s = 4'b1111; end
      4'hA: begin k = K_ABUS | K_M;                  s = 4'b1010; end
      4'hB: begin k = K_ABUS | K_DRW | K_LDZ | K_M;  s = 4'b1110; end
      4'hC: begin k = K_LDZ | K_LDC;                 s = 4'b0110; end
      4'hD: begin k = K_ABUS | K_DRW | K_M;          s = 4'b1010; end
      default: k = 16'h0000;
    endcase
    return mk((n == 1) ? 3'b001 : 3'b010, k, s, op, 1'b0, 1'b1);
  endfunction

  task automatic tick();
    @(posedge T3);
    #1;
  endtask

  task automatic check(input string name, input obs_t e);
    n_chk++;
    if (W === e.w && CTRL === e.ctrl && S === e.s && SEL === e.sel &&
        STOP === e.stop && BUSY === e.busy) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got W=%b CTRL=%h S=%b SEL=%b STOP=%b BUSY=%b; want W=%b CTRL=%h S=%b SEL=%b STOP=%b BUSY=%b",
               name, W, CTRL, S, SEL, STOP, BUSY,
               e.w, e.ctrl, e.s, e.sel, e.stop, e.busy);
    end
  endtask

  task automatic do_reset(input string tag);
    START = 1'b0;
    CLR   = 1'b1;
    tick();
    tick();
    CLR   = 1'b0;
    check({tag, "_reset"}, o_idle);
  endtask

  task automatic start_run(input string tag);
    SW    = 3'b000;
    START = 1'b1;
    tick();
    START = 1'b0;
    check({tag, "_prep"}, o_prep);
    tick();
    check({tag, "_fetch0"}, o_fetch);
  endtask

  // Entered in a FETCH cycle; leaves the DUT in the following FETCH cycle
  task automatic exec_one(input string tag, input logic [3:0] ir, input logic c,
                          input logic z, input int beats, input obs_t e1, input obs_t e2);
    IR = ir;
    C  = c;
    Z  = z;
    tick();
    check({tag, "_w1"}, e1);
    if (beats == 2) begin
      tick();
      check({tag, "_w2"}, e2);
    end
    tick();
`ifdef SINGLE_STEP_EN
    check({tag, "_pause"}, o_pause);
    START = 1'b1;
    tick();
    START = 1'b0;
`endif
    check({tag, "_fetch"}, o_fetch);
  endtask

  task automatic console_run(input string tag, input logic [2:0] md, input int steps);
    bit fs;
    int rix;
    fs  = 1'b1;
    rix = 0;
    do_reset(tag);
    SW = md;
    for (int i = 0; i < steps; i++) begin
      START = 1'b1;
      tick();
      START = 1'b0;
      check($sformatf("%s_con%0d", tag, i), con_model(md, fs, rix));
      fs = 1'b0;
      if (md == 3'b100)      rix = (rix + 1) % 4;
      else if (md == 3'b011) rix = (rix + 2) % 4;
      // switch changes while busy must not affect the latched mode
      SW = 3'($urandom_range(0, 7));
      tick();
      check($sformatf("%s_pause%0d", tag, i), o_pause);
      if (i == 0) begin
        tick();
        check($sformatf("%s_pausehold", tag), o_pause);
      end
    end
  endtask

  initial begin
    obs_t e1, e2;
    logic [3:0] op;
    logic c, z;

    o_idle  = mk(3'b000, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    o_pause = mk(3'b000, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    o_halt  = mk(3'b000, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    o_prep  = mk(3'b001, K_SELCTL | K_SBUS | K_LPC, 4'b0000, 4'b0000, 1'b0, 1'b1);
    o_fetch = mk(3'b001, K_LIR | K_PCINC, 4'b0000, 4'b0000, 1'b0, 1'b1);

    //           ir     c     z     n  beat1 ctrl                               s1       beat2 ctrl               s2
    tbl[0]  = '{4'h0, 1'b0, 1'b0, 1, 16'h0000,                                4'b0000, 16'h0000,                4'b0000};
    tbl[1]  = '{4'h1, 1'b0, 1'b0, 1, K_ABUS | K_DRW | K_LDZ | K_LDC | K_CIN,  4'b1001, 16'h0000,                4'b0000};
    tbl[2]  = '{4'h2, 1'b1, 1'b0, 1, K_ABUS | K_DRW | K_LDZ | K_LDC,          4'b0110, 16'h0000,                4'b0000};
    tbl[3]  = '{4'h3, 1'b0, 1'b1, 1, K_ABUS | K_DRW | K_LDZ | K_M,            4'b1011, 16'h0000,                4'b0000};
    tbl[4]  = '{4'h4, 1'b0, 1'b0, 1, K_ABUS | K_DRW | K_LDZ | K_LDC,          4'b0000, 16'h0000,                4'b0000};
    tbl[5]  = '{4'h5, 1'b0, 1'b0, 2, K_ABUS | K_M | K_LAR,                    4'b1010, K_MBUS | K_DRW,          4'b0000};
    tbl[6]  = '{4'h6, 1'b0, 1'b0, 2, K_ABUS | K_M | K_LAR,                    4'b1111, K_ABUS | K_M | K_MEMW,   4'b1010};
    tbl[7]  = '{4'h7, 1'b1, 1'b0, 1, K_PCADD,                                 4'b0000, 16'h0000,                4'b0000};
    tbl[8]  = '{4'h7, 1'b0, 1'b1, 1, 16'h0000,                                4'b0000, 16'h0000,                4'b0000};
    tbl[9]  = '{4'h8, 1'b0, 1'b1, 1, K_PCADD,                                 4'b0000, 16'h0000,                4'b0000};
    tbl[10] = '{4'h8, 1'b1, 1'b0, 1, 16'h0000,                                4'b0000, 16'h0000,                4'b0000};
    tbl[11] = '{4'h9, 1'b0, 1'b0, 1, K_ABUS | K_M | K_LPC,                    4'b1111, 16'h0000,                4'b0000};
    tbl[12] = '{4'hA, 1'b0, 1'b0, 1, K_ABUS | K_M,                            4'b1010, 16'h0000,                4'b0000};
    tbl[13] = '{4'hB, 1'b0, 1'b0, 1, K_ABUS | K_DRW | K_LDZ | K_M,            4'b1110, 16'h0000,                4'b0000};
    tbl[14] = '{4'hC, 1'b1, 1'b1, 1, K_LDZ | K_LDC,                           4'b0110, 16'h0000,                4'b0000};
    tbl[15] = '{4'hD, 1'b0, 1'b0, 1, K_ABUS | K_DRW | K_M,                    4'b1010, 16'h0000,                4'b0000};
    tbl[16] = '{4'hF, 1'b1, 1'b1, 1, 16'h0000,                                4'b0000, 16'h0000,                4'b0000};

    CLR = 1'b1; START = 1'b0; SW = 3'b000; IR = '0; C = 1'b0; Z = 1'b0;

    // Reset state and idle hold
    do_reset("init");
    tick();
    check("idle_hold", o_idle);

    // Undefined modes: START ignored
    for (int m = 5; m < 8; m++) begin
      SW = 3'(m);
      START = 1'b1;
      tick();
      START = 1'b0;
      check($sformatf("sw%0d_ignored", m), o_idle);
    end

    // Directed console sessions
    console_run("wreg", 3'b100, 5);
    console_run("wmem", 3'b001, 3);
    console_run("rmem", 3'b010, 3);
    console_run("rreg", 3'b011, 3);

    // Hand-written opcode table
    do_reset("tbl");
    start_run("tbl");
    for (int i = 0; i < 17; i++) begin
      e1 = mk(3'b001, tbl[i].c1, tbl[i].s1, tbl[i].ir, 1'b0, 1'b1);
      e2 = mk(3'b010, tbl[i].c2, tbl[i].s2, tbl[i].ir, 1'b0, 1'b1);
      exec_one($sformatf("tbl%0d_op%h", i, tbl[i].ir), tbl[i].ir, tbl[i].c, tbl[i].z,
               tbl[i].beats, e1, e2);
    end

    // Random instruction stream against the model
    do_reset("rnd");
    start_run("rnd");
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op == 4'hE) op = 4'hF;
      c = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      exec_one($sformatf("rnd%0d_op%h", i, op), op, c, z, op_beats(op),
               exec_model(op, c, z, 1), exec_model(op, c, z, 2));
    end

    // Random console sessions
    for (int i = 0; i < 12; i++) begin
      console_run($sformatf("rcon%0d", i), 3'($urandom_range(1, 4)), $urandom_range(1, 6));
    end

    // CLR during the second beat of LD
    do_reset("clrld");
    start_run("clrld");
    IR = 4'h5;
    tick();
    check("clrld_w1", exec_model(4'h5, 1'b0, 1'b0, 1));
    tick();
    check("clrld_w2", exec_model(4'h5, 1'b0, 1'b0, 2));
    CLR = 1'b1;
    tick();
    check("clrld_clr1", o_idle);
    tick();
    check("clrld_clr2", o_idle);
    CLR = 1'b0;
    tick();
    check("clrld_after", o_idle);

    // STP enters HALT; START ignored; CLR exits
    do_reset("halt");
    start_run("halt");
    IR = 4'hE;
    tick();
    check("halt_exec", mk(3'b001, 16'h0000, 4'b0000, 4'hE, 1'b0, 1'b1));
    tick();
    check("halt_enter", o_halt);
    for (int i = 0; i < 3; i++) begin
      START = 1'b1;
      tick();
      START = 1'b0;
      check($sformatf("halt_start%0d", i), o_halt);
      tick();
      check($sformatf("halt_hold%0d", i), o_halt);
    end
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("halt_clr", o_idle);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
